// File: rtl/vit_conv0_dma_rd_arb_pkg.sv
// Shared widths, client IDs and order-entry layout for the conv0 DMA read arbiter.
// Burst-length width comes from log2AXI_BURST_LEN (defaults to 4 when not set).
`ifndef log2AXI_BURST_LEN
`define log2AXI_BURST_LEN 4
`endif

package vit_conv0_dma_rd_arb_pkg;

  localparam int LEN_W = `log2AXI_BURST_LEN;
  localparam int REQ_W = LEN_W + 64;
  localparam int ORD_W = 1 + LEN_W;

  typedef enum logic {
    CLI_DAT = 1'b0,
    CLI_WT  = 1'b1
  } client_e;

  typedef struct packed {
    client_e          id;
    logic [LEN_W-1:0] len;
  } ord_entry_t;

  function automatic logic [LEN_W-1:0] req_len(
    input logic [REQ_W-1:0] pd
  );
    return pd[REQ_W-1 -: LEN_W];
  endfunction

endpackage

// File: rtl/vit_dma_ord_fifo.sv
// Order FIFO: remembers which client owns each outstanding read and its burst length.
// Flop array with a registered occupancy count.
module vit_dma_ord_fifo
  import vit_conv0_dma_rd_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ord_entry_t push_data,
  input  logic       pop,
  output ord_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ord_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vit_conv0_dma_rd_arb.sv
// Merges feature-map and weight DMA reads onto MCIF and routes responses back in order.
// VIT_DMA_RD_ARB_WT_PRIO_EN selects fixed wt-over-dat priority instead of round-robin.
module vit_conv0_dma_rd_arb
  import vit_conv0_dma_rd_arb_pkg::*;
#(
  parameter int ORD_DEPTH = 16,
  parameter int RESP_W    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dat_rd_req_vld,
  output logic              dat_rd_req_rdy,
  input  logic [REQ_W-1:0]  dat_rd_req_pd,
  input  logic              wt_rd_req_vld,
  output logic              wt_rd_req_rdy,
  input  logic [REQ_W-1:0]  wt_rd_req_pd,
  output logic              mcif_rd_req_vld,
  input  logic              mcif_rd_req_rdy,
  output logic [REQ_W-1:0]  mcif_rd_req_pd,
  input  logic              mcif_rd_resp_vld,
  output logic              mcif_rd_resp_rdy,
  input  logic [RESP_W-1:0] mcif_rd_resp_pd,
  output logic              dat_rd_resp_vld,
  input  logic              dat_rd_resp_rdy,
  output logic [RESP_W-1:0] dat_rd_resp_pd,
  output logic              wt_rd_resp_vld,
  input  logic              wt_rd_resp_rdy,
  output logic [RESP_W-1:0] wt_rd_resp_pd,
  output logic              idle
);

  logic             req_vld_q;
  logic [REQ_W-1:0] req_pd_q;
  logic             load;
  logic             can_gnt;
  logic             gnt_dat;
  logic             gnt_wt;
  logic             gnt_any;
  logic [REQ_W-1:0] gnt_pd;
  ord_entry_t       push_ent;
  ord_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LEN_W-1:0] beat_cnt;
  logic             head_wt;
  logic             sel_rdy;
  logic             beat;
  logic             last_beat;

  // Full uses the registered count, so a same-cycle pop never frees a slot.
  assign load    = ~req_vld_q | mcif_rd_req_rdy;
  assign can_gnt = rst_n & load & ~fifo_full;

`ifdef VIT_DMA_RD_ARB_WT_PRIO_EN
  always_comb begin
    gnt_dat = 1'b0;
    gnt_wt  = 1'b0;
    if (can_gnt) begin
      gnt_wt  = wt_rd_req_vld;
      gnt_dat = dat_rd_req_vld & ~wt_rd_req_vld;
    end
  end
`else
  client_e last_gnt;

  always_comb begin
    gnt_dat = 1'b0;
    gnt_wt  = 1'b0;
    if (can_gnt) begin
      unique case ({dat_rd_req_vld, wt_rd_req_vld})
        2'b11: begin
          gnt_dat = (last_gnt == CLI_WT);
          gnt_wt  = (last_gnt == CLI_DAT);
        end
        2'b10:   gnt_dat = 1'b1;
        2'b01:   gnt_wt  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= CLI_WT;
    end else if (gnt_any) begin
      last_gnt <= gnt_wt ? CLI_WT : CLI_DAT;
    end
  end
`endif

  assign gnt_any        = gnt_dat | gnt_wt;
  assign gnt_pd         = gnt_wt ? wt_rd_req_pd : dat_rd_req_pd;
  assign dat_rd_req_rdy = gnt_dat;
  assign wt_rd_req_rdy  = gnt_wt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_vld_q <= 1'b0;
      req_pd_q  <= '0;
    end else if (load) begin
      req_vld_q <= gnt_any;
      if (gnt_any) begin
        req_pd_q <= gnt_pd;
      end
    end
  end

  assign mcif_rd_req_vld = req_vld_q;
  assign mcif_rd_req_pd  = req_pd_q;

  assign push_ent.id  = gnt_wt ? CLI_WT : CLI_DAT;
  assign push_ent.len = req_len(gnt_pd);

  vit_dma_ord_fifo #(
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_any),
    .push_data (push_ent),
    .pop       (last_beat),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_wt = (head.id == CLI_WT);
  assign sel_rdy = head_wt ? wt_rd_resp_rdy : dat_rd_resp_rdy;

  assign mcif_rd_resp_rdy = rst_n & ~fifo_empty & sel_rdy;
  assign dat_rd_resp_vld  = rst_n & mcif_rd_resp_vld & ~fifo_empty & ~head_wt;
  assign wt_rd_resp_vld   = rst_n & mcif_rd_resp_vld & ~fifo_empty & head_wt;
  assign dat_rd_resp_pd   = mcif_rd_resp_pd;
  assign wt_rd_resp_pd    = mcif_rd_resp_pd;

  assign beat      = mcif_rd_resp_vld & mcif_rd_resp_rdy;
  assign last_beat = beat & (beat_cnt == head.len);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (last_beat) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign idle = ~rst_n | (fifo_empty & ~req_vld_q);

  // A response beat with no outstanding order entry is a protocol error.
  a_resp_has_order: assert property (
    @(posedge clk) disable iff (!rst_n)
    mcif_rd_resp_vld |-> !fifo_empty
  );

endmodule

// File: tb/tb_vit_conv0_dma_rd_arb.sv
// Self-checking bench for vit_conv0_dma_rd_arb with a queue-based reference model.
// Honours VIT_DMA_RD_ARB_WT_PRIO_EN for the expected arbitration order.
module tb_vit_conv0_dma_rd_arb;
  import vit_conv0_dma_rd_arb_pkg::*;

  localparam int ORD_DEPTH = 16;
  localparam int RESP_W    = 256;
`ifdef VIT_DMA_RD_ARB_WT_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dat_rd_req_vld;
  logic              dat_rd_req_rdy;
  logic [REQ_W-1:0]  dat_rd_req_pd;
  logic              wt_rd_req_vld;
  logic              wt_rd_req_rdy;
  logic [REQ_W-1:0]  wt_rd_req_pd;
  logic              mcif_rd_req_vld;
  logic              mcif_rd_req_rdy;
  logic [REQ_W-1:0]  mcif_rd_req_pd;
  logic              mcif_rd_resp_vld;
  logic              mcif_rd_resp_rdy;
  logic [RESP_W-1:0] mcif_rd_resp_pd;
  logic              dat_rd_resp_vld;
  logic              dat_rd_resp_rdy;
  logic [RESP_W-1:0] dat_rd_resp_pd;
  logic              wt_rd_resp_vld;
  logic              wt_rd_resp_rdy;
  logic [RESP_W-1:0] wt_rd_resp_pd;
  logic              idle;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding reads as client*32+len, plus the output slot.
  int               ord_q[$];
  bit               exp_vld;
  logic [REQ_W-1:0] exp_pd;
  int               last_c;
  int               beat_n;

  always #5 clk = ~clk;

  vit_conv0_dma_rd_arb #(
    .ORD_DEPTH (ORD_DEPTH),
    .RESP_W    (RESP_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dat_rd_req_vld   (dat_rd_req_vld),
    .dat_rd_req_rdy   (dat_rd_req_rdy),
    .dat_rd_req_pd    (dat_rd_req_pd),
    .wt_rd_req_vld    (wt_rd_req_vld),
    .wt_rd_req_rdy    (wt_rd_req_rdy),
    .wt_rd_req_pd     (wt_rd_req_pd),
    .mcif_rd_req_vld  (mcif_rd_req_vld),
    .mcif_rd_req_rdy  (mcif_rd_req_rdy),
    .mcif_rd_req_pd   (mcif_rd_req_pd),
    .mcif_rd_resp_vld (mcif_rd_resp_vld),
    .mcif_rd_resp_rdy (mcif_rd_resp_rdy),
    .mcif_rd_resp_pd  (mcif_rd_resp_pd),
    .dat_rd_resp_vld  (dat_rd_resp_vld),
    .dat_rd_resp_rdy  (dat_rd_resp_rdy),
    .dat_rd_resp_pd   (dat_rd_resp_pd),
    .wt_rd_resp_vld   (wt_rd_resp_vld),
    .wt_rd_resp_rdy   (wt_rd_resp_rdy),
    .wt_rd_resp_pd    (wt_rd_resp_pd),
    .idle             (idle)
  );

  function automatic logic [REQ_W-1:0] mk_pd(input int len);
    logic [REQ_W-1:0] p;
    p = {$urandom, $urandom};
    p[REQ_W-1 -: LEN_W] = len[LEN_W-1:0];
    return p;
  endfunction

  function automatic logic [RESP_W-1:0] rand_resp();
    logic [RESP_W-1:0] v;
    for (int k = 0; k < RESP_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int exp_grant();
    if (exp_vld && !mcif_rd_req_rdy) return -1;
    if (ord_q.size() >= ORD_DEPTH) return -1;
    if (dat_rd_req_vld && wt_rd_req_vld) return PRIO ? 1 : 1 - last_c;
    if (dat_rd_req_vld) return 0;
    if (wt_rd_req_vld) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    ord_q.delete();
    exp_vld = 1'b0;
    exp_pd  = '0;
    last_c  = 1;
    beat_n  = 0;
  endtask

  // Advance one cycle from just after a negedge and update the model.
  task automatic step();
    int g;
    bit beat;
    int hc;
    int hl;
    logic [REQ_W-1:0] gp;
    g    = exp_grant();
    beat = 1'b0;
    hc   = 0;
    hl   = 0;
    if (ord_q.size() > 0) begin
      hc   = ord_q[0] / 32;
      hl   = ord_q[0] % 32;
      beat = mcif_rd_resp_vld && (hc == 1 ? wt_rd_resp_rdy : dat_rd_resp_rdy);
    end
    gp = (g == 1) ? wt_rd_req_pd : dat_rd_req_pd;
    @(posedge clk);
    if (!exp_vld || mcif_rd_req_rdy) begin
      exp_vld = (g >= 0);
      if (g >= 0) exp_pd = gp;
    end
    if (beat) begin
      beat_n++;
      if (beat_n == hl + 1) begin
        void'(ord_q.pop_front());
        beat_n = 0;
      end
    end
    if (g >= 0) begin
      ord_q.push_back(g * 32 + int'(gp[REQ_W-1 -: LEN_W]));
      last_c = g;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    int hc;
    guard = 0;
    dat_rd_req_vld  = 1'b0;
    wt_rd_req_vld   = 1'b0;
    mcif_rd_req_rdy = 1'b1;
    dat_rd_resp_rdy = 1'b1;
    wt_rd_resp_rdy  = 1'b1;
    while (ord_q.size() > 0 && guard < 300) begin
      mcif_rd_resp_vld = 1'b1;
      mcif_rd_resp_pd  = rand_resp();
      #1;
      hc = ord_q[0] / 32;
      checks++;
      if (dat_rd_resp_vld !== (hc == 0) || wt_rd_resp_vld !== (hc == 1)) begin
        errors++;
        $display("FAIL drain_route: dat_vld=%b wt_vld=%b head=%0d", dat_rd_resp_vld, wt_rd_resp_vld, hc);
      end
      checks++;
      if (mcif_rd_resp_rdy !== 1'b1 || dat_rd_resp_pd !== mcif_rd_resp_pd) begin
        errors++;
        $display("FAIL drain_rdy_pd: rdy=%b required 1", mcif_rd_resp_rdy);
      end
      step();
      guard++;
    end
    mcif_rd_resp_vld = 1'b0;
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left", ord_q.size());
    end
    #1;
    checks++;
    if (idle !== (ord_q.size() == 0 && !exp_vld)) begin
      errors++;
      $display("FAIL drain_idle: got %b", idle);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dat_rd_req_vld = 1'b1;
    wt_rd_req_vld  = 1'b1;
    dat_rd_req_pd  = mk_pd(1);
    wt_rd_req_pd   = mk_pd(2);
    mcif_rd_req_rdy  = 1'b1;
    mcif_rd_resp_vld = 1'b0;
    mcif_rd_resp_pd  = '0;
    dat_rd_resp_rdy  = 1'b1;
    wt_rd_resp_rdy   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (idle !== 1'b1 || dat_rd_req_rdy !== 1'b0 || wt_rd_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_idle: idle=%b dat_rdy=%b wt_rdy=%b required 1/0/0", idle, dat_rd_req_rdy, wt_rd_req_rdy);
    end
    checks++;
    if (mcif_rd_req_vld !== 1'b0 || mcif_rd_req_pd !== '0) begin
      errors++;
      $display("FAIL reset_req_reg: vld=%b pd=%h required 0", mcif_rd_req_vld, mcif_rd_req_pd);
    end
    checks++;
    if (mcif_rd_resp_rdy !== 1'b0 || dat_rd_resp_vld !== 1'b0 || wt_rd_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: rdy=%b dat_vld=%b wt_vld=%b required 0", mcif_rd_resp_rdy, dat_rd_resp_vld, wt_rd_resp_vld);
    end
    rst_n = 1'b1;
    dat_rd_req_vld = 1'b0;
    wt_rd_req_vld  = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [REQ_W-1:0] prev_pd;
    int exp_c;
    prev_pd = '0;
    dat_rd_req_vld  = 1'b1;
    wt_rd_req_vld   = 1'b1;
    mcif_rd_req_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dat_rd_req_pd = mk_pd(0);
      wt_rd_req_pd  = mk_pd(0);
      #1;
      exp_c = PRIO ? 1 : (i % 2);
      checks++;
      if (dat_rd_req_rdy !== (exp_c == 0) || wt_rd_req_rdy !== (exp_c == 1)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: dat_rdy=%b wt_rdy=%b required client %0d", i, dat_rd_req_rdy, wt_rd_req_rdy, exp_c);
      end
      checks++;
      if (mcif_rd_req_vld !== (i > 0) || (i > 0 && mcif_rd_req_pd !== prev_pd)) begin
        errors++;
        $display("FAIL rr_out[%0d]: vld=%b pd=%h required pd %h", i, mcif_rd_req_vld, mcif_rd_req_pd, prev_pd);
      end
      prev_pd = (exp_c == 1) ? wt_rd_req_pd : dat_rd_req_pd;
      step();
    end
    dat_rd_req_vld = 1'b0;
    wt_rd_req_vld  = 1'b0;
    drain();
  endtask

  task automatic test_burst_routing();
    dat_rd_req_vld = 1'b1;
    wt_rd_req_vld  = 1'b0;
    dat_rd_req_pd  = mk_pd(15);
    #1;
    checks++;
    if (dat_rd_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL burst_dat_gnt: rdy=%b required 1", dat_rd_req_rdy);
    end
    step();
    dat_rd_req_vld = 1'b0;
    wt_rd_req_vld  = 1'b1;
    wt_rd_req_pd   = mk_pd(3);
    #1;
    checks++;
    if (wt_rd_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL burst_wt_gnt: rdy=%b required 1", wt_rd_req_rdy);
    end
    step();
    wt_rd_req_vld   = 1'b0;
    dat_rd_resp_rdy = 1'b1;
    wt_rd_resp_rdy  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      mcif_rd_resp_vld = 1'b1;
      mcif_rd_resp_pd  = rand_resp();
      #1;
      checks++;
      if (dat_rd_resp_vld !== (k <= 16) || wt_rd_resp_vld !== (k > 16) || mcif_rd_resp_rdy !== 1'b1) begin
        errors++;
        $display("FAIL burst_beat[%0d]: dat_vld=%b wt_vld=%b rdy=%b", k, dat_rd_resp_vld, wt_rd_resp_vld, mcif_rd_resp_rdy);
      end
      checks++;
      if (wt_rd_resp_pd !== mcif_rd_resp_pd) begin
        errors++;
        $display("FAIL burst_pd[%0d]: pd passthrough differs", k);
      end
      step();
    end
    mcif_rd_resp_vld = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || mcif_rd_resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL burst_idle: idle=%b resp_rdy=%b required 1/0", idle, mcif_rd_resp_rdy);
    end
    step();
  endtask

  task automatic test_fifo_full();
    dat_rd_req_vld   = 1'b1;
    wt_rd_req_vld    = 1'b0;
    mcif_rd_req_rdy  = 1'b1;
    mcif_rd_resp_vld = 1'b0;
    dat_rd_resp_rdy  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dat_rd_req_pd = mk_pd(0);
      #1;
      checks++;
      if (dat_rd_req_rdy !== 1'b1) begin
        errors++;
        $display("FAIL full_fill[%0d]: rdy=%b required 1", i, dat_rd_req_rdy);
      end
      step();
    end
    dat_rd_req_pd = mk_pd(0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dat_rd_req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL full_block[%0d]: rdy=%b required 0", i, dat_rd_req_rdy);
      end
      step();
    end
    mcif_rd_resp_vld = 1'b1;
    mcif_rd_resp_pd  = rand_resp();
    #1;
    checks++;
    if (dat_rd_req_rdy !== 1'b0 || mcif_rd_resp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_cycle: req_rdy=%b resp_rdy=%b required 0/1", dat_rd_req_rdy, mcif_rd_resp_rdy);
    end
    step();
    mcif_rd_resp_vld = 1'b0;
    #1;
    checks++;
    if (dat_rd_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_regrant: rdy=%b required 1", dat_rd_req_rdy);
    end
    step();
    drain();
  endtask

  task automatic test_resp_backpressure();
    dat_rd_req_vld = 1'b0;
    wt_rd_req_vld  = 1'b1;
    wt_rd_req_pd   = mk_pd(3);
    #1;
    step();
    wt_rd_req_vld  = 1'b0;
    dat_rd_req_vld = 1'b1;
    dat_rd_req_pd  = mk_pd(0);
    #1;
    step();
    dat_rd_req_vld   = 1'b0;
    mcif_rd_resp_vld = 1'b1;
    dat_rd_resp_rdy  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wt_rd_resp_rdy  = (i >= 3 && i < 5) || i >= 7;
      mcif_rd_resp_pd = rand_resp();
      #1;
      checks++;
      if (mcif_rd_resp_rdy !== wt_rd_resp_rdy || dat_rd_resp_vld !== 1'b0 || wt_rd_resp_vld !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: rdy=%b dat_vld=%b wt_vld=%b required %b/0/1", i, mcif_rd_resp_rdy, dat_rd_resp_vld, wt_rd_resp_vld, wt_rd_resp_rdy);
      end
      step();
    end
    wt_rd_resp_rdy = 1'b1;
    #1;
    checks++;
    if (dat_rd_resp_vld !== 1'b1 || wt_rd_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_dat_after: dat_vld=%b wt_vld=%b required 1/0", dat_rd_resp_vld, wt_rd_resp_vld);
    end
    step();
    mcif_rd_resp_vld = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: idle=%b required 1", idle);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic [REQ_W-1:0] pd;
    dat_rd_req_vld = 1'b1;
    wt_rd_req_vld  = 1'b0;
    dat_rd_req_pd  = mk_pd(15);
    #1;
    step();
    dat_rd_req_vld   = 1'b0;
    mcif_rd_resp_vld = 1'b1;
    dat_rd_resp_rdy  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      mcif_rd_resp_pd = rand_resp();
      #1;
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mcif_rd_resp_rdy !== 1'b0 || dat_rd_resp_vld !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_reset: rdy=%b dat_vld=%b idle=%b required 0/0/1", mcif_rd_resp_rdy, dat_rd_resp_vld, idle);
    end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mcif_rd_resp_vld = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || mcif_rd_req_vld !== 1'b0 || dat_rd_resp_vld !== 1'b0 || wt_rd_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: idle=%b req_vld=%b dat_vld=%b wt_vld=%b", idle, mcif_rd_req_vld, dat_rd_resp_vld, wt_rd_resp_vld);
    end
    step();
    dat_rd_req_vld = 1'b1;
    pd = mk_pd(0);
    dat_rd_req_pd = pd;
    #1;
    checks++;
    if (dat_rd_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_new_gnt: rdy=%b required 1", dat_rd_req_rdy);
    end
    step();
    dat_rd_req_vld = 1'b0;
    #1;
    checks++;
    if (mcif_rd_req_vld !== 1'b1 || mcif_rd_req_pd !== pd) begin
      errors++;
      $display("FAIL rst_mid_new_out: vld=%b pd=%h required 1/%h", mcif_rd_req_vld, mcif_rd_req_pd, pd);
    end
    step();
    drain();
  endtask

  task automatic test_random();
    int g;
    int hc;
    bit have;
    for (int c = 0; c < 500; c++) begin
      dat_rd_req_vld   = $urandom_range(0, 1);
      wt_rd_req_vld    = $urandom_range(0, 1);
      dat_rd_req_pd    = mk_pd($urandom_range(0, 3));
      wt_rd_req_pd     = mk_pd($urandom_range(0, 3));
      mcif_rd_req_rdy  = ($urandom_range(0, 3) != 0);
      dat_rd_resp_rdy  = ($urandom_range(0, 3) != 0);
      wt_rd_resp_rdy   = ($urandom_range(0, 3) != 0);
      mcif_rd_resp_vld = (ord_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mcif_rd_resp_pd  = rand_resp();
      #1;
      g    = exp_grant();
      have = (ord_q.size() > 0);
      hc   = have ? ord_q[0] / 32 : 0;
      checks++;
      if (dat_rd_req_rdy !== (g == 0) || wt_rd_req_rdy !== (g == 1)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: dat_rdy=%b wt_rdy=%b required %0d", c, dat_rd_req_rdy, wt_rd_req_rdy, g);
      end
      checks++;
      if (mcif_rd_req_vld !== exp_vld || (exp_vld && mcif_rd_req_pd !== exp_pd)) begin
        errors++;
        $display("FAIL rand_req_out[%0d]: vld=%b pd=%h required %b/%h", c, mcif_rd_req_vld, mcif_rd_req_pd, exp_vld, exp_pd);
      end
      checks++;
      if (mcif_rd_resp_rdy !== (have && (hc == 1 ? wt_rd_resp_rdy : dat_rd_resp_rdy))) begin
        errors++;
        $display("FAIL rand_resp_rdy[%0d]: got %b", c, mcif_rd_resp_rdy);
      end
      checks++;
      if (dat_rd_resp_vld !== (mcif_rd_resp_vld && have && hc == 0) || wt_rd_resp_vld !== (mcif_rd_resp_vld && have && hc == 1)) begin
        errors++;
        $display("FAIL rand_route[%0d]: dat_vld=%b wt_vld=%b head=%0d", c, dat_rd_resp_vld, wt_rd_resp_vld, hc);
      end
      checks++;
      if (idle !== (!have && !exp_vld)) begin
        errors++;
        $display("FAIL rand_idle[%0d]: got %b", c, idle);
      end
      step();
    end
    drain();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    dat_rd_req_vld = 1'b0;
    wt_rd_req_vld  = 1'b0;
    dat_rd_req_pd  = '0;
    wt_rd_req_pd   = '0;
    mcif_rd_req_rdy  = 1'b0;
    mcif_rd_resp_vld = 1'b0;
    mcif_rd_resp_pd  = '0;
    dat_rd_resp_rdy  = 1'b0;
    wt_rd_resp_rdy   = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_routing();
    test_fifo_full();
    test_resp_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vit_conv0_dma_rd_arb.md
VIT_CONV0_DMA_RD_ARB -- requirements
Module: vit_conv0_dma_rd_arb

Interface
REQ-001 The block SHALL have these parameters:
- ORD_DEPTH, 16, order-FIFO entries (power of 2, at least 2).
- RESP_W, 256, read-response data width.

REQ-002 The block SHALL have these ports (REQ_W = `log2AXI_BURST_LEN+64; pd = {len,base,offset}):
- clk  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- dat_rd_req_vld / dat_rd_req_rdy / dat_rd_req_pd  in / out / in  1/1/REQ_W  client 0 (feature-map DMA) request.
- wt_rd_req_vld / wt_rd_req_rdy / wt_rd_req_pd  in / out / in  1/1/REQ_W  client 1 (weight DMA) request.
- mcif_rd_req_vld / mcif_rd_req_rdy / mcif_rd_req_pd  out / in / out  1/1/REQ_W  merged request to MCIF.
- mcif_rd_resp_vld / mcif_rd_resp_rdy / mcif_rd_resp_pd  in / out / in  1/1/RESP_W  MCIF response beats, in request order.
- dat_rd_resp_vld / dat_rd_resp_rdy / dat_rd_resp_pd  out / in / out  1/1/RESP_W  client 0 return.
- wt_rd_resp_vld / wt_rd_resp_rdy / wt_rd_resp_pd  out / in / out  1/1/RESP_W  client 1 return.
- idle  out  1  no request held, nothing outstanding.

Function
REQ-003 Every handshake SHALL be vld&rdy in the same cycle; pd is sampled only on transfer.
REQ-004 The request output SHALL be one register stage: mcif_rd_req_vld/pd come from flops, and the register loads when empty or when mcif_rd_req_vld&mcif_rd_req_rdy (full throughput, 1 request/cycle).
REQ-005 A grant SHALL occur only when the output register can load and order-FIFO count < ORD_DEPTH, using the registered count; a same-cycle pop does not free a slot.
REQ-006 The client rdy SHALL equal its grant, combinational from vld inputs and state; at most one grant per cycle.
REQ-007 Round-robin: last_gnt flop resets to wt; with both vld, grant the client not equal to last_gnt; with one vld, grant it; last_gnt updates on every grant.
REQ-008 Each grant SHALL push {client_id, len=pd[REQ_W-1 -: `log2AXI_BURST_LEN]} into the order FIFO in the same cycle; request latency grant-to-mcif_rd_req_vld is 1 cycle.
REQ-009 Response routing: FIFO head selects client; beats per entry = len+1; beat counter counts 0..len, clears on the last beat and pops the head on the last beat.
REQ-010 sel_resp_vld = mcif_rd_resp_vld & ~fifo_empty & (head==client); mcif_rd_resp_rdy = ~fifo_empty & selected client rdy; resp pd is passed through combinationally to both clients.
REQ-011 FIFO empty SHALL hold mcif_rd_resp_rdy low (beats stall; a simulation assertion flags this as a protocol error).
REQ-012 A push and a pop in the same cycle SHALL leave the count unchanged; the pointers wrap modulo ORD_DEPTH.
REQ-013 idle = fifo_empty & ~mcif_rd_req_vld.

Reset
REQ-014 When rst_n=0 at the clock edge, the block SHALL clear the output register (mcif_rd_req_vld=0, pd=0), the FIFO pointers and count, the beat counter, and set last_gnt=wt.
REQ-015 In reset, all rdy/vld outputs SHALL be 0 and idle SHALL be 1.
REQ-016 Reset mid-burst SHALL discard outstanding entries; the DMAs and MCIF are reset together.

Configuration
REQ-017 With VIT_DMA_RD_ARB_WT_PRIO_EN defined, arbitration SHALL be fixed priority with wt over dat, and last_gnt is unused.
REQ-018 Without VIT_DMA_RD_ARB_WT_PRIO_EN, arbitration SHALL be round-robin per REQ-007.

Structure
REQ-019 The shared package SHALL hold the client-ID encoding (DAT=0, WT=1), the order-entry width (1+`log2AXI_BURST_LEN) and the REQ_W localparam.
REQ-020 The order FIFO SHALL be a sub-module, vit_dma_ord_fifo (flop array, registered count, full/empty outputs).

Verification
REQ-021 The bench SHALL cover these scenarios:
- Both clients vld continuously, mcif_rd_req_rdy=1: grants alternate dat,wt,dat,...; first output at cycle 1 after the first grant.
- With VIT_DMA_RD_ARB_WT_PRIO_EN, both vld for 4 cycles: 4 wt grants, 0 dat grants.
- dat len=15, then wt len=3; MCIF returns 20 beats: beats 1-16 go to dat, 17-20 to wt; FIFO empty afterwards, idle=1.
- 16 grants with no responses: the 17th request sees rdy=0 until the first last-beat pop, then is granted the following cycle.
- wt_rd_resp_rdy=0 while the head is wt: mcif_rd_resp_rdy=0, no dat beat is delivered, and the beat counter holds.
- rst_n=0 mid-burst (beat 5 of 16): next cycle idle=1 and all vld=0; a new dat request is then granted normally.
